// File: rtl/axi_lite_slave_resp.sv
// rtl/axi_lite_slave_resp.sv - AXI4-Lite slave responder: word-addressed register memory with delayed B/R responses
module axi_lite_slave_resp #(
  parameter int                        AXI_DATA_WIDTH  = 32,
  parameter int                        AXI_ADDR_WIDTH  = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = 32'h1000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  = 32'h0000_FFFF,
  parameter int                        MEM_DEPTH       = 64,
  parameter int                        RESP_MIN_DELAY  = 2,
  parameter int                        RESP_MAX_DELAY  = 17,
  parameter bit                        RANDOM_DELAY    = 1'b0,
  parameter logic [15:0]               LFSR_SEED       = 16'hACE1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     araddr,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [AXI_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_W);
  localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W      = $clog2(RESP_MAX_DELAY + 1);
  localparam int DELAY_SPAN = RESP_MAX_DELAY - RESP_MIN_DELAY + 1;
  localparam int EW         = AXI_ADDR_WIDTH + 1;

  localparam logic [EW-1:0] WIN_LO = {1'b0, AXI_ADDR_OFFSET};
  localparam logic [EW-1:0] WIN_HI = {1'b0, AXI_ADDR_OFFSET} + {1'b0, AXI_ADDR_RANGE};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DELAY = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_DELAY = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  function automatic logic [1:0] decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [EW-1:0] ext;
    logic [EW-1:0] off;
    ext = {1'b0, addr};
    off = ext - WIN_LO;
    if (ext < WIN_LO || ext > WIN_HI)
      decode = RESP_DECERR;
    else if ((off >> ADDR_LSB) >= EW'(MEM_DEPTH))
      decode = RESP_SLVERR;
    else
      decode = RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [EW-1:0] off;
    off = {1'b0, addr} - WIN_LO;
    word_idx = IDX_W'(off >> ADDR_LSB);
  endfunction

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] delay_of(input logic [15:0] s);
    int unsigned d;
    if (RANDOM_DELAY)
      d = RESP_MIN_DELAY + (32'(s) % DELAY_SPAN);
    else
      d = RESP_MIN_DELAY;
    delay_of = CNT_W'(d);
  endfunction

  logic [1:0]                w_state_q, w_state_d;
  logic                      aw_got_q, aw_got_d;
  logic                      w_got_q, w_got_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic [CNT_W-1:0]          wcnt_q, wcnt_d;
  logic [1:0]                bresp_q, bresp_d;

  logic [1:0]                r_state_q, r_state_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CNT_W-1:0]          rcnt_q, rcnt_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic [15:0]               lfsr_q, lfsr_d;
  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic        aw_fire, w_fire, ar_fire, wr_accept, wr_commit;
  logic [15:0] lfsr_mid;
  logic [1:0]  wr_resp, rd_resp;

  assign awready = (w_state_q == W_IDLE) && !aw_got_q && !areset;
  assign wready  = (w_state_q == W_IDLE) && !w_got_q && !areset;
  assign arready = (r_state_q == R_IDLE) && !areset;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign rvalid  = (r_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign aw_fire   = awvalid && awready;
  assign w_fire    = wvalid && wready;
  assign ar_fire   = arvalid && arready;
  assign wr_accept = (w_state_q == W_IDLE) && (aw_got_q || aw_fire) && (w_got_q || w_fire);
  assign wr_resp   = decode(awaddr_q);
  assign rd_resp   = decode(araddr_q);
  assign wr_commit = (w_state_q == W_DELAY) && (wcnt_q == CNT_W'(1)) && (wr_resp == RESP_OKAY);

  // A write accepted in the same cycle as a read consumes the current LFSR value first
  always_comb begin
    lfsr_mid = wr_accept ? lfsr_next(lfsr_q) : lfsr_q;
    lfsr_d   = ar_fire ? lfsr_next(lfsr_mid) : lfsr_mid;
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_got_d = 1'b1;
          awaddr_d = awaddr;
        end
        if (w_fire) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (wr_accept) begin
          w_state_d = W_DELAY;
          wcnt_d    = delay_of(lfsr_q);
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      W_DELAY: begin
        wcnt_d = wcnt_q - CNT_W'(1);
        if (wcnt_q == CNT_W'(1)) begin
          w_state_d = W_RESP;
          bresp_d   = wr_resp;
        end
      end
      W_RESP: begin
        if (bready)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_d = R_DELAY;
          araddr_d  = araddr;
          rcnt_d    = delay_of(lfsr_mid);
        end
      end
      R_DELAY: begin
        rcnt_d = rcnt_q - CNT_W'(1);
        if (rcnt_q == CNT_W'(1)) begin
          r_state_d = R_DATA;
          rresp_d   = rd_resp;
          rdata_d   = (rd_resp == RESP_OKAY) ? mem_q[word_idx(araddr_q)] : '0;
        end
      end
      R_DATA: begin
        if (rready)
          r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read sampling uses mem_q, so a commit on the same edge is not yet visible
  always_comb begin
    mem_d = mem_q;
    if (wr_commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i])
          mem_d[word_idx(awaddr_q)][i*8 +: 8] = wdata_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wcnt_q    <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      lfsr_q    <= LFSR_SEED;
      for (int i = 0; i < MEM_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      lfsr_q    <= lfsr_d;
      for (int i = 0; i < MEM_DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_resp.sv
// tb/tb_axi_lite_slave_resp.sv - bench for axi_lite_slave_resp: fixed-delay instance 0, LFSR-delay instance 1
module tb_axi_lite_slave_resp;

  logic aclk;
  logic areset;

  logic [1:0][31:0] awaddr, wdata, araddr;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       awvalid, wvalid, bready, arvalid, rready;
  wire  [1:0]       awready, wready, bvalid, arready, rvalid;
  wire  [1:0][1:0]  bresp, rresp;
  wire  [1:0][31:0] rdata;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          delay;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [2][64];
  logic [15:0] lfsr_m;
  int          checks = 0;
  int          errors = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_slave_resp #(.RANDOM_DELAY(1'b0)) dut_fixed (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0])
  );

  axi_lite_slave_resp #(.RANDOM_DELAY(1'b1)) dut_rand (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a < 32'h1000_0000 || a > 32'h1000_FFFF) return 2'b11;
    if (((a - 32'h1000_0000) >> 2) >= 32'd64) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [5:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'h1000_0000) >> 2;
    return o[5:0];
  endfunction

  function automatic int next_delay(input int k);
    int d;
    if (k == 0) return 2;
    d = 2 + int'(lfsr_m % 16'd16);
    lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    return d;
  endfunction

  task automatic reset_models();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++)
        mem_m[k][i] = 32'h0;
    lfsr_m = 16'hACE1;
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead, input int hold);
    exp_t       e;
    int         n;
    bit         aw_done, w_done, awf, wf;
    logic [1:0] br0;
    e.resp  = exp_resp(a);
    e.data  = 32'h0;
    e.delay = next_delay(k);
    if (e.resp == 2'b00)
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[k][widx(a)][i*8 +: 8] = d[i*8 +: 8];
    exp_q.push_back(e);
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge aclk);
      awaddr[k]  = a;
      wdata[k]   = d;
      wstrb[k]   = s;
      awvalid[k] = !aw_done && (n >= w_lead);
      wvalid[k]  = !w_done;
      if (w_done && !aw_done) check("wready_low_after_w", wready[k], 1'b0);
      awf = awvalid[k] && awready[k];
      wf  = wvalid[k] && wready[k];
      @(posedge aclk);
      aw_done = aw_done || awf;
      w_done  = w_done || wf;
      n++;
    end
    check("aw_w_handshake", {aw_done, w_done}, 2'b11);
    @(negedge aclk);
    awvalid[k] = 1'b0;
    wvalid[k]  = 1'b0;
    check("awready_busy", awready[k], 1'b0);
    check("wready_busy", wready[k], 1'b0);
    n = 0;
    while (!bvalid[k] && n < 40) begin
      @(negedge aclk);
      n++;
    end
    e = exp_q.pop_front();
    check("b_delay", n, e.delay);
    check("bresp", bresp[k], e.resp);
    br0 = bresp[k];
    for (int i = 0; i < hold; i++) begin
      awvalid[k] = 1'b1;
      @(negedge aclk);
      check("bvalid_held", bvalid[k], 1'b1);
      check("bresp_stable", bresp[k], br0);
      check("aw_blocked_during_b", awready[k], 1'b0);
    end
    awvalid[k] = 1'b0;
    bready[k]  = 1'b1;
    @(negedge aclk);
    bready[k] = 1'b0;
    check("bvalid_clear", bvalid[k], 1'b0);
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input int hold);
    exp_t        e;
    int          n;
    bit          done, f;
    logic [31:0] rd0;
    e.resp  = exp_resp(a);
    e.data  = (e.resp == 2'b00) ? mem_m[k][widx(a)] : 32'h0;
    e.delay = next_delay(k);
    exp_q.push_back(e);
    done = 0; n = 0;
    while (!done && n < 50) begin
      @(negedge aclk);
      araddr[k]  = a;
      arvalid[k] = 1'b1;
      f = arready[k];
      @(posedge aclk);
      done = f;
      n++;
    end
    check("ar_handshake", done, 1'b1);
    @(negedge aclk);
    arvalid[k] = 1'b0;
    check("arready_busy", arready[k], 1'b0);
    n = 0;
    while (!rvalid[k] && n < 40) begin
      @(negedge aclk);
      n++;
    end
    e = exp_q.pop_front();
    check("r_delay", n, e.delay);
    check("rresp", rresp[k], e.resp);
    check("rdata", rdata[k], e.data);
    rd0 = rdata[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check("rvalid_held", rvalid[k], 1'b1);
      check("rdata_stable", rdata[k], rd0);
    end
    rready[k] = 1'b1;
    @(negedge aclk);
    rready[k] = 1'b0;
    check("rvalid_clear", rvalid[k], 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    bit          saw_rvalid;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    areset = 1'b1;
    reset_models();
    repeat (2) @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      check("rst_awready", awready[k], 1'b0);
      check("rst_arready", arready[k], 1'b0);
      check("rst_bvalid", bvalid[k], 1'b0);
      check("rst_rvalid", rvalid[k], 1'b0);
      check("rst_rdata", rdata[k], 32'h0);
    end
    areset = 1'b0;
    @(negedge aclk);
    check("idle_awready", awready[0], 1'b1);
    check("idle_arready", arready[0], 1'b1);

    // basic write/read, same-cycle AW and W
    do_write(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(0, 32'h1000_0004, 0);

    // W leads AW by 3 cycles, B held off for 5 cycles
    do_write(0, 32'h1000_000C, 32'h1234_5678, 4'hF, 3, 5);
    do_read(0, 32'h1000_000C, 3);

    // byte strobes
    do_write(0, 32'h1000_0008, 32'h1122_3344, 4'hF, 0, 0);
    do_write(0, 32'h1000_0008, 32'hAABB_CCDD, 4'b0101, 1, 0);
    do_read(0, 32'h1000_0008, 0);
    check("strobe_merge_const", rdata[0], 32'h11BB_33DD);
    do_write(0, 32'h1000_0004, 32'hFFFF_FFFF, 4'h0, 0, 0);
    do_read(0, 32'h1000_0007, 0);

    // decode boundaries
    do_write(0, 32'h2000_0000, 32'h5555_5555, 4'hF, 0, 0);
    do_write(0, 32'h1000_0100, 32'h6666_6666, 4'hF, 0, 0);
    do_read(0, 32'h1000_0100, 0);
    do_read(0, 32'h2000_0000, 0);
    do_read(0, 32'h0FFF_FFFC, 0);
    do_read(0, 32'h1000_FFFF, 0);
    do_read(0, 32'h1001_0000, 0);
    do_read(0, 32'h1000_00FC, 0);
    do_read(0, 32'h1000_0000, 0);

    // reset while a read sits in R_DELAY
    @(negedge aclk);
    araddr[0]  = 32'h1000_0004;
    arvalid[0] = 1'b1;
    @(negedge aclk);
    arvalid[0] = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    check("rst_mid_awready", awready[0], 1'b0);
    check("rst_mid_wready", wready[0], 1'b0);
    check("rst_mid_arready", arready[0], 1'b0);
    check("rst_mid_bvalid", bvalid[0], 1'b0);
    check("rst_mid_bresp", bresp[0], 2'b00);
    check("rst_mid_rvalid", rvalid[0], 1'b0);
    check("rst_mid_rresp", rresp[0], 2'b00);
    check("rst_mid_rdata", rdata[0], 32'h0);
    areset = 1'b0;
    reset_models();
    saw_rvalid = 0;
    repeat (20) begin
      @(negedge aclk);
      saw_rvalid = saw_rvalid || rvalid[0];
    end
    check("no_rvalid_after_reset", saw_rvalid, 1'b0);
    do_read(0, 32'h1000_0004, 0);
    do_read(0, 32'h1000_0008, 0);

    // LFSR-delayed instance, random traffic against the memory and LFSR models
    for (int t = 0; t < 1000; t++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h2000_0000 + $urandom_range(0, 255);
        1:       a = 32'h1000_0100 + ($urandom_range(0, 1000) << 2);
        default: a = 32'h1000_0000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
      else
        do_read(1, a, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
